// File: rtl/alu_seq.sv
// Single-operation command sequencer in front of the alu block: accepts a request, issues it,
// waits for alu_ack (with timeout) and returns result, flags and an error bit.
module alu_seq #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [8:0]  IDLE_SEL = 9'h100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [8:0]  req_fnct,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [31:0] alu_inp_a,
    output logic [31:0] alu_inp_b,
    output logic [8:0]  alu_fnct_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_cf,
    input  logic        alu_nf,
    input  logic        alu_zf,
    input  logic        alu_vf,
    input  logic        alu_ack,
    output logic        stray_ack
);

    localparam int unsigned TimerW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q;
    logic [TimerW-1:0]   timer_q;

    assign req_ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_flags    <= '0;
            rsp_err      <= 1'b0;
            alu_inp_a    <= '0;
            alu_inp_b    <= '0;
            alu_fnct_sel <= IDLE_SEL;
            stray_ack    <= 1'b0;
        end else begin
            // An ack with nothing in flight is only recorded, never turned into a response.
            if (alu_ack && state_q != StWait) begin
                stray_ack <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (req_fnct != IDLE_SEL) begin
                            alu_inp_a    <= req_a;
                            alu_inp_b    <= req_b;
                            alu_fnct_sel <= req_fnct;
                            timer_q      <= '0;
                            state_q      <= StWait;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_flags <= '0;
                            rsp_valid <= 1'b1;
                            state_q   <= StResp;
                        end
                    end
                end
                StWait: begin
                    // Ack takes priority over a coincident timeout.
                    if (alu_ack) begin
                        rsp_data     <= alu_out;
                        rsp_flags    <= {alu_cf, alu_nf, alu_zf, alu_vf};
                        rsp_err      <= 1'b0;
                        rsp_valid    <= 1'b1;
                        alu_fnct_sel <= IDLE_SEL;
                        state_q      <= StResp;
                    end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                        rsp_data     <= '0;
                        rsp_flags    <= '0;
                        rsp_err      <= 1'b1;
                        rsp_valid    <= 1'b1;
                        alu_fnct_sel <= IDLE_SEL;
                        state_q      <= StResp;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Command initiator for the `alu` block. It drives the ALU's `inp_a`/`inp_b`/`fnct_sel` side and consumes `out`, the flags and `alu_ack`.
- Accepts one operation at a time from an upstream valid/ready request port and waits for the ALU acknowledge, with a timeout.
- Returns result, flags and an error bit on a valid/ready response port.
- Sits between the core control path and `alu`, and is the only driver of the ALU's input bus.

Parameters:
- TIMEOUT, 16, number of WAIT cycles without `alu_ack` before the operation is aborted with an error; minimum 2.
- IDLE_SEL, 9'h100, `fnct_sel` code driven whenever no operation is in flight. Never issued as a real operation.

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_fnct  in  9  ALU function code
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  captured ALU result
- rsp_flags  out  4  captured {cf,nf,zf,vf}
- rsp_err  out  1  1 = timeout or illegal function
- alu_inp_a  out  32  to ALU `inp_a`
- alu_inp_b  out  32  to ALU `inp_b`
- alu_fnct_sel  out  9  to ALU `fnct_sel`
- alu_out  in  32  from ALU `out`
- alu_cf / alu_nf / alu_zf / alu_vf  in  1 each  ALU flags
- alu_ack  in  1  ALU completion pulse; `alu_out` and flags are valid in the same cycle
- stray_ack  out  1  sticky: `alu_ack` seen outside WAIT

Behaviour:
- Reset, sampled on the rising edge while `rst`=1:
  - state=IDLE, req_ready=1, rsp_valid=0.
  - rsp_data=0, rsp_flags=0, rsp_err=0.
  - alu_inp_a=0, alu_inp_b=0, alu_fnct_sel=IDLE_SEL.
  - timer=0, stray_ack=0.
  - Reset mid-operation discards any in-flight or pending response. No response is ever produced for it.
- Registers:
  - All outputs are registered; `req_ready` is a decode of the state register.
  - The timer is $clog2(TIMEOUT) bits.
- IDLE:
  - `req_valid`=1 with `req_fnct`≠IDLE_SEL: latch `req_a`/`req_b`/`req_fnct` into `alu_inp_a`/`alu_inp_b`/`alu_fnct_sel`, timer=0, go WAIT.
  - `req_valid`=1 with `req_fnct`=IDLE_SEL: no ALU issue, `alu_fnct_sel` stays IDLE_SEL. Set rsp_err=1, rsp_data=0, rsp_flags=0, go RESP.
- WAIT:
  - `alu_inp_a`/`alu_inp_b`/`alu_fnct_sel` are held stable throughout.
  - On `alu_ack`=1: capture `alu_out` and flags, rsp_err=0, alu_fnct_sel=IDLE_SEL, go RESP.
  - Else, if timer=TIMEOUT-1: rsp_err=1, rsp_data=0, rsp_flags=0, alu_fnct_sel=IDLE_SEL, go RESP.
  - Else timer+1.
  - If `alu_ack` and timeout coincide, the ack wins.
- RESP:
  - rsp_valid=1; rsp_* held stable until `rsp_ready`=1.
  - On the handshake: rsp_valid=0 next cycle, go IDLE.
  - `req_valid` is ignored while in RESP.
- Operand outputs:
  - `alu_inp_a`/`alu_inp_b` keep their last values after completion until the next accept.
  - Only `alu_fnct_sel` returns to IDLE_SEL.
- stray_ack:
  - Set by `alu_ack`=1 in IDLE or RESP; cleared only by reset.
  - A stray ack never creates a response.
- Timing, with the request accepted at edge N and ack sampled at edge N+k (k≥1):
  - `alu_fnct_sel` is valid from after edge N.
  - `rsp_valid` is high from after edge N+k.
  - Timeout: `rsp_valid` is high after edge N+TIMEOUT.
  - Minimum request-to-request spacing is 3 cycles (k=1, rsp_ready held high).

Test Plan:
- Reset: hold `rst`=1 for 1 cycle. After the edge: alu_fnct_sel=9'h100, req_ready=1, rsp_valid=0, stray_ack=0, alu_inp_a=0.
- Normal op: req a=32'h8, b=32'h4, fnct=9'h040. ALU model acks at N+2 with out=32'hC, flags 4'b0000. Expect:
  - alu_fnct_sel=9'h040 during N+1..N+2, then 9'h100.
  - rsp_valid after N+2 with rsp_data=32'h0000000C, rsp_err=0.
- Timeout (TIMEOUT=16), fnct=9'h080, no ack:
  - rsp_valid rises after edge N+16 with rsp_err=1, rsp_data=0.
  - alu_fnct_sel=9'h100 from the same point.
- Ack/timeout collision: ack at edge N+16 with out=32'hFFFFFFFC, nf=1. Expect rsp_err=0, rsp_data=32'hFFFFFFFC, rsp_flags=4'b0100.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles with req_valid=1 and a new request pending.
  - Response must stay stable, req_ready=0, and the second request must not be accepted until the cycle after the rsp handshake.
- Illegal code and stray ack:
  - req fnct=9'h100 gives a response with rsp_err=1 one cycle after accept, and alu_fnct_sel never leaves 9'h100.
  - An alu_ack pulse in IDLE sets stray_ack=1 and produces no rsp_valid.
  - Asserting rst during WAIT returns to the reset values and produces no response.
